// File: rtl/ring_wr_cntrl_pkg.sv
// rtl/ring_wr_cntrl_pkg.sv - shared defaults and FSM encoding for the ring-buffer write controller
package ring_wr_cntrl_pkg;

    // Default ring-buffer address width and ADC sample width
    localparam int RING_SIZE   = 12;
    localparam int RING_DWIDTH = 16;

    // Width of the saturating missed-trigger counter
    localparam int MISSED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } ring_state_t;

endpackage

// File: rtl/ring_posttrig_cnt.sv
// rtl/ring_posttrig_cnt.sv - post-trigger sample down-counter with last-sample flag
module ring_posttrig_cnt #(
    parameter int SIZE = 12
) (
    input  logic            sysclk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [SIZE-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_last
);

    logic [SIZE-1:0] r_remaining;

    // Load on trigger, count down once per accepted post-trigger sample
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_val;
        end else if (i_dec && (r_remaining != '0)) begin
            r_remaining <= r_remaining - 1'b1;
        end
    end

    // The sample accepted while one remains is the final one to be written
    assign o_last = (r_remaining == {{(SIZE-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ring_wr_cntrl.sv
// rtl/ring_wr_cntrl.sv - triggered ring-buffer acquisition write controller
module ring_wr_cntrl
    import ring_wr_cntrl_pkg::*;
#(
    parameter int SIZE   = RING_SIZE,
    parameter int DWIDTH = RING_DWIDTH
) (
    input  logic                sysclk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [DWIDTH-1:0]   din,
    input  logic                arm,
    input  logic                trigger,
    input  logic [SIZE-1:0]     posttrig_i,
    input  logic                rd_request,
    input  logic                ro_done_n,
    output logic                wr_en,
    output logic [SIZE-1:0]     wr_addr,
    output logic [DWIDTH-1:0]   wr_data,
    output logic [SIZE-1:0]     ain,
    output logic [SIZE-1:0]     trig_addr,
    output logic                busy,
    output logic                data_ready,
    output logic                wrapped,
    output logic                overrun,
    output logic [MISSED_W-1:0] missed_trig
);

    ring_state_t         r_state;
    logic                r_wr_en;
    logic [SIZE-1:0]     r_wr_addr;
    logic [DWIDTH-1:0]   r_wr_data;
    logic [SIZE-1:0]     r_ain;
    logic [SIZE-1:0]     r_trig_addr;
    logic                r_wrapped;
    logic                r_overrun;
    logic [MISSED_W-1:0] r_missed;
    logic                r_rd_request_q;

    logic            w_busy;
    logic            w_accept;
    logic [SIZE-1:0] w_ain_next;
    logic            w_trig_armed;
    logic            w_cnt_load;
    logic            w_cnt_dec;
    logic            w_cnt_last;
    logic            w_missed;
    logic            w_rd_fall;

    assign w_busy       = (r_state == ST_ARMED) || (r_state == ST_POST);
    // The reader owns the RAM while rd_request is high, so samples are dropped
    assign w_accept     = sample_valid && w_busy && !rd_request;
    assign w_ain_next   = r_ain + {{(SIZE-1){1'b0}}, w_accept};
    assign w_trig_armed = trigger && (r_state == ST_ARMED);
    assign w_cnt_load   = w_trig_armed && (posttrig_i != '0);
    // A sample on the trigger cycle is still pre-trigger, so only POST decrements
    assign w_cnt_dec    = w_accept && (r_state == ST_POST);
    // Arm and trigger together in IDLE just arms; it is not a missed trigger
    assign w_missed     = trigger && (((r_state == ST_IDLE) && !arm) ||
                                      (r_state == ST_POST) || (r_state == ST_FROZEN));
    assign w_rd_fall    = r_rd_request_q && !rd_request;

    ring_posttrig_cnt #(
        .SIZE (SIZE)
    ) u_posttrig_cnt (
        .sysclk     (sysclk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (posttrig_i),
        .i_dec      (w_cnt_dec),
        .o_last     (w_cnt_last)
    );

    // Acquisition FSM, write port, address pointer and status flags
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_ain          <= '0;
            r_trig_addr    <= '0;
            r_wrapped      <= 1'b0;
            r_overrun      <= 1'b0;
            r_missed       <= '0;
            r_rd_request_q <= 1'b0;
        end else begin
            r_rd_request_q <= rd_request;
            r_wr_en        <= w_accept;

            if (w_accept) begin
                r_wr_addr <= r_ain;
                r_wr_data <= din;
                r_ain     <= w_ain_next;
                if (r_ain == {SIZE{1'b1}}) begin
                    r_wrapped <= 1'b1;
                end
            end

            if (sample_valid && w_busy && rd_request) begin
                r_overrun <= 1'b1;
            end

            if (w_missed && (r_missed != {MISSED_W{1'b1}})) begin
                r_missed <= r_missed + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        r_state   <= ST_ARMED;
                        r_wrapped <= 1'b0;
                        r_overrun <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (trigger) begin
                        r_trig_addr <= w_ain_next;
                        r_state     <= w_cnt_load ? ST_POST : ST_FROZEN;
                    end
                end
                ST_POST: begin
                    if (w_accept && w_cnt_last) begin
                        r_state <= ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    // An aborted readout (words still remaining) keeps the capture re-readable
                    if (w_rd_fall && !ro_done_n) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign ain         = r_ain;
    assign trig_addr   = r_trig_addr;
    assign busy        = w_busy;
    assign data_ready  = (r_state == ST_FROZEN);
    assign wrapped     = r_wrapped;
    assign overrun     = r_overrun;
    assign missed_trig = r_missed;

endmodule

// File: tb/tb_ring_wr_cntrl.sv
// tb/tb_ring_wr_cntrl.sv - self-checking bench for ring_wr_cntrl
module tb_ring_wr_cntrl;

    localparam int DEPTH = 4096;
    localparam int P_IDLE = 0, P_ARMED = 1, P_POST = 2, P_FROZEN = 3;

    logic        sysclk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] din = '0;
    logic        arm = 1'b0;
    logic        trigger = 1'b0;
    logic [11:0] posttrig_i = '0;
    logic        rd_request = 1'b0;
    logic        ro_done_n = 1'b1;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic [11:0] ain;
    logic [11:0] trig_addr;
    logic        busy;
    logic        data_ready;
    logic        wrapped;
    logic        overrun;
    logic [7:0]  missed_trig;

    int checks = 0;
    int errors = 0;

    int m_phase = P_IDLE;
    int m_rem = 0;
    int m_ain = 0;
    int m_trig = 0;
    int m_wr_addr = 0;
    int m_wr_data = 0;
    int m_missed = 0;
    bit m_wr_en = 0;
    bit m_wrapped = 0;
    bit m_overrun = 0;
    bit m_rq_q = 0;

    ring_wr_cntrl dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .din          (din),
        .arm          (arm),
        .trigger      (trigger),
        .posttrig_i   (posttrig_i),
        .rd_request   (rd_request),
        .ro_done_n    (ro_done_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .ain          (ain),
        .trig_addr    (trig_addr),
        .busy         (busy),
        .data_ready   (data_ready),
        .wrapped      (wrapped),
        .overrun      (overrun),
        .missed_trig  (missed_trig)
    );

    always #5 sysclk = ~sysclk;

    // Advance one clock, updating the reference model from the applied inputs
    task automatic tick();
        bit acc;
        bit bsy;
        bsy = (m_phase == P_ARMED) || (m_phase == P_POST);
        if (rst) begin
            m_phase = P_IDLE; m_rem = 0; m_ain = 0; m_trig = 0;
            m_wr_en = 0; m_wr_addr = 0; m_wr_data = 0;
            m_wrapped = 0; m_overrun = 0; m_missed = 0; m_rq_q = 0;
        end else begin
            acc = sample_valid && bsy && !rd_request;
            m_wr_en = acc;
            if (sample_valid && bsy && rd_request) m_overrun = 1;
            if (acc) begin
                m_wr_addr = m_ain;
                m_wr_data = din;
                if (m_ain == DEPTH - 1) m_wrapped = 1;
                m_ain = (m_ain + 1) % DEPTH;
            end
            if (trigger && ((m_phase == P_IDLE && !arm) || m_phase == P_POST || m_phase == P_FROZEN)
                && m_missed < 255) m_missed++;
            case (m_phase)
                P_IDLE: if (arm) begin m_phase = P_ARMED; m_wrapped = 0; m_overrun = 0; end
                P_ARMED: if (trigger) begin
                    m_trig = m_ain;
                    if (posttrig_i != 0) begin m_phase = P_POST; m_rem = posttrig_i; end
                    else m_phase = P_FROZEN;
                end
                P_POST: if (acc) begin
                    m_rem--;
                    if (m_rem == 0) m_phase = P_FROZEN;
                end
                default: if (m_rq_q && !rd_request && !ro_done_n) m_phase = P_IDLE;
            endcase
            m_rq_q = rd_request;
        end
        @(posedge sysclk);
        #1;
    endtask

    task automatic quiet();
        rst = 0; sample_valid = 0; arm = 0; trigger = 0;
        posttrig_i = '0; rd_request = 0; ro_done_n = 1;
    endtask

    task automatic readout_done();
        quiet();
        rd_request = 1; tick();
        rd_request = 0; ro_done_n = 0; tick();
        quiet();
    endtask

    task automatic test_reset();
        quiet();
        rst = 1; tick(); tick();
        rst = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", data_ready); end
        checks++; if (ain !== 12'd0 || trig_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got ain=%0d trig=%0d want 0/0", ain, trig_addr); end
        checks++; if (wr_en !== 1'b0 || wr_addr !== 12'd0 || wr_data !== 16'd0) begin errors++; $display("FAIL reset_wrport got en=%0b a=%0d d=%0h want 0", wr_en, wr_addr, wr_data); end
        checks++; if (wrapped !== 1'b0 || overrun !== 1'b0 || missed_trig !== 8'd0) begin errors++; $display("FAIL reset_flags got w=%0b o=%0b m=%0d want 0", wrapped, overrun, missed_trig); end
    endtask

    task automatic test_basic_capture();
        int nw;
        logic [15:0] dq[$];
        nw = 0;
        quiet();
        arm = 1; tick(); arm = 0;
        for (int i = 0; i < 11; i++) begin
            if (i == 5) begin
                sample_valid = 0; trigger = 1; posttrig_i = 12'd3;
            end else begin
                sample_valid = 1; trigger = 0; din = 16'($urandom); dq.push_back(din);
            end
            tick();
            if (i == 5) begin
                checks++; if (trig_addr !== 12'd5) begin errors++; $display("FAIL basic_trig_addr got %0d want 5", trig_addr); end
            end
            if (wr_en === 1'b1) begin
                checks++;
                if (nw >= 8 || wr_addr !== 12'(nw) || wr_data !== dq[nw]) begin
                    errors++; $display("FAIL basic_write got a=%0d d=%0h want write %0d", wr_addr, wr_data, nw);
                end
                nw++;
                if (nw == 8) begin
                    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL basic_frozen_after_w7 got %0b want 1", data_ready); end
                end
            end
        end
        checks++; if (nw != 8) begin errors++; $display("FAIL basic_write_count got %0d want 8", nw); end
        checks++; if (ain !== 12'd8 || data_ready !== 1'b1) begin errors++; $display("FAIL basic_end got ain=%0d rdy=%0b want 8/1", ain, data_ready); end
        readout_done();
        checks++; if (busy !== 1'b0 || data_ready !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%0b rdy=%0b want 0/0", busy, data_ready); end
    endtask

    task automatic test_wrap();
        int exp_a[3];
        exp_a[0] = 4094; exp_a[1] = 4095; exp_a[2] = 0;
        quiet();
        rst = 1; tick(); rst = 0;
        arm = 1; tick(); arm = 0;
        sample_valid = 1;
        for (int i = 0; i < 4094; i++) begin din = 16'(i); tick(); end
        checks++; if (ain !== 12'd4094) begin errors++; $display("FAIL wrap_preset got %0d want 4094", ain); end
        for (int i = 0; i < 3; i++) begin
            din = 16'($urandom); tick();
            checks++; if (wr_en !== 1'b1 || wr_addr !== 12'(exp_a[i])) begin errors++; $display("FAIL wrap_addr got en=%0b a=%0d want %0d", wr_en, wr_addr, exp_a[i]); end
        end
        sample_valid = 0;
        checks++; if (wrapped !== 1'b1 || ain !== 12'd1) begin errors++; $display("FAIL wrap_flag got w=%0b ain=%0d want 1/1", wrapped, ain); end
        trigger = 1; tick(); trigger = 0;
        readout_done();
        checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_sticky got %0b want 1", wrapped); end
        arm = 1; tick(); arm = 0;
        checks++; if (wrapped !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wrap_arm_clear got w=%0b busy=%0b want 0/1", wrapped, busy); end
    endtask

    task automatic test_trig_zero();
        logic [15:0] d;
        // continues from ARMED with ain = 1
        quiet();
        sample_valid = 1; din = 16'h1234; tick();
        d = 16'($urandom);
        din = d; trigger = 1; posttrig_i = 12'd0; tick();
        trigger = 0;
        checks++; if (wr_en !== 1'b1 || wr_addr !== 12'd2 || wr_data !== d) begin errors++; $display("FAIL tz_write got en=%0b a=%0d d=%0h want 1/2/%0h", wr_en, wr_addr, wr_data, d); end
        checks++; if (data_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tz_frozen got rdy=%0b busy=%0b want 1/0", data_ready, busy); end
        checks++; if (trig_addr !== 12'd3) begin errors++; $display("FAIL tz_trig_addr got %0d want 3", trig_addr); end
        din = 16'hBEEF; tick();
        checks++; if (wr_en !== 1'b0 || ain !== 12'd3) begin errors++; $display("FAIL tz_no_write_frozen got en=%0b ain=%0d want 0/3", wr_en, ain); end
        sample_valid = 0;
    endtask

    task automatic test_readout();
        quiet();
        rd_request = 1; tick();
        rd_request = 0; ro_done_n = 1; tick();
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL ro_abort got rdy=%0b want 1", data_ready); end
        rd_request = 1; tick();
        rd_request = 0; ro_done_n = 0; tick();
        checks++; if (data_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ro_done got rdy=%0b busy=%0b want 0/0", data_ready, busy); end
        quiet();
    endtask

    task automatic test_overrun_missed();
        quiet();
        rst = 1; tick(); rst = 0;
        arm = 1; tick(); arm = 0;
        rd_request = 1; sample_valid = 1;
        for (int i = 0; i < 2; i++) begin
            din = 16'($urandom); tick();
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL ovr_no_write got %0b want 0", wr_en); end
        end
        checks++; if (overrun !== 1'b1 || ain !== 12'd0) begin errors++; $display("FAIL ovr_flag got o=%0b ain=%0d want 1/0", overrun, ain); end
        quiet();
        trigger = 1; tick(); trigger = 0;
        readout_done();
        checks++; if (overrun !== 1'b1 || missed_trig !== 8'd0) begin errors++; $display("FAIL ovr_sticky got o=%0b m=%0d want 1/0", overrun, missed_trig); end
        trigger = 1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (missed_trig !== 8'd3) begin errors++; $display("FAIL missed_3 got %0d want 3", missed_trig); end
        for (int i = 0; i < 260; i++) tick();
        trigger = 0;
        checks++; if (missed_trig !== 8'd255) begin errors++; $display("FAIL missed_sat got %0d want 255", missed_trig); end
        arm = 1; tick(); arm = 0;
        checks++; if (overrun !== 1'b0 || missed_trig !== 8'd255) begin errors++; $display("FAIL arm_clear got o=%0b m=%0d want 0/255", overrun, missed_trig); end
        trigger = 1; tick(); trigger = 0;
        readout_done();
    endtask

    task automatic test_rst_post();
        quiet();
        sample_valid = 1; din = 16'h5555;
        arm = 1; tick(); arm = 0;
        trigger = 1; posttrig_i = 12'd5; tick(); trigger = 0;
        tick();
        checks++; if (busy !== 1'b1 || wr_en !== 1'b1) begin errors++; $display("FAIL rp_in_post got busy=%0b en=%0b want 1/1", busy, wr_en); end
        rst = 1; tick();
        checks++; if (busy !== 1'b0 || data_ready !== 1'b0 || ain !== 12'd0 || wr_en !== 1'b0) begin errors++; $display("FAIL rp_abort got busy=%0b rdy=%0b ain=%0d en=%0b want 0", busy, data_ready, ain, wr_en); end
        checks++; if (wrapped !== 1'b0 || overrun !== 1'b0 || missed_trig !== 8'd0 || trig_addr !== 12'd0) begin errors++; $display("FAIL rp_flags got w=%0b o=%0b m=%0d t=%0d want 0", wrapped, overrun, missed_trig, trig_addr); end
        rst = 0; tick();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rp_no_write_after got %0b want 0", wr_en); end
        quiet();
    endtask

    task automatic test_arm_trig_same();
        quiet();
        arm = 1; trigger = 1; posttrig_i = 12'd4; tick();
        quiet();
        checks++; if (busy !== 1'b1 || data_ready !== 1'b0 || missed_trig !== 8'd0) begin errors++; $display("FAIL at_same got busy=%0b rdy=%0b m=%0d want 1/0/0", busy, data_ready, missed_trig); end
        arm = 1; tick(); arm = 0;
        checks++; if (busy !== 1'b1 || data_ready !== 1'b0) begin errors++; $display("FAIL arm_ignored got busy=%0b rdy=%0b want 1/0", busy, data_ready); end
        trigger = 1; tick(); trigger = 0;
        readout_done();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(999) == 0);
            sample_valid = ($urandom_range(3) != 0);
            din          = 16'($urandom);
            arm          = ($urandom_range(7) == 0);
            trigger      = ($urandom_range(9) == 0);
            posttrig_i   = 12'($urandom_range(6));
            rd_request   = (m_phase == P_FROZEN) ? ($urandom_range(1) == 0) : ($urandom_range(15) == 0);
            ro_done_n    = ($urandom_range(1) == 0);
            tick();
            checks++;
            if (wr_en !== m_wr_en || (m_wr_en && (wr_addr !== 12'(m_wr_addr) || wr_data !== 16'(m_wr_data)))) begin
                errors++; $display("FAIL rnd_write c=%0d got en=%0b a=%0d d=%0h want en=%0b a=%0d d=%0h", c, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
            end
            checks++;
            if (ain !== 12'(m_ain) || trig_addr !== 12'(m_trig)) begin
                errors++; $display("FAIL rnd_addr c=%0d got ain=%0d trig=%0d want %0d/%0d", c, ain, trig_addr, m_ain, m_trig);
            end
            checks++;
            if (busy !== (m_phase == P_ARMED || m_phase == P_POST) || data_ready !== (m_phase == P_FROZEN)) begin
                errors++; $display("FAIL rnd_state c=%0d got busy=%0b rdy=%0b want phase %0d", c, busy, data_ready, m_phase);
            end
            checks++;
            if (wrapped !== m_wrapped || overrun !== m_overrun || missed_trig !== 8'(m_missed)) begin
                errors++; $display("FAIL rnd_flags c=%0d got w=%0b o=%0b m=%0d want %0b/%0b/%0d", c, wrapped, overrun, missed_trig, m_wrapped, m_overrun, m_missed);
            end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_wrap();
        test_trig_zero();
        test_readout();
        test_overrun_missed();
        test_rst_post();
        test_arm_trig_same();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ring_wr_cntrl.md
RING_WR_CNTRL -- requirements
Module: ring_wr_cntrl

Interface
REQ-001 SHALL have parameters: SIZE, 12, ring-buffer address width; DWIDTH, 16, sample width.
REQ-002 SHALL have port sysclk  in  1  clock, all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: sample_valid  in  1  ADC sample strobe; din  in  DWIDTH  ADC sample.
REQ-005 SHALL have ports: arm  in  1  start acquisition; trigger  in  1  trigger event; posttrig_i  in  SIZE  post-trigger sample count.
REQ-006 SHALL have ports: rd_request  in  1  reader active; ro_done_n  in  1  reader words remaining (low = readout complete).
REQ-007 SHALL have ports: wr_en  out  1; wr_addr  out  SIZE; wr_data  out  DWIDTH  (ring-buffer write port).
REQ-008 SHALL have ports: ain  out  SIZE  next write address; trig_addr  out  SIZE  ain captured at trigger.
REQ-009 SHALL have ports: busy  out  1; data_ready  out  1; wrapped  out  1; overrun  out  1; missed_trig  out  8.

Function
REQ-010 SHALL implement FSM IDLE, ARMED, POST, FROZEN; busy = ARMED|POST; data_ready = FROZEN.
REQ-011 IDLE: arm -> ARMED; clear wrapped and overrun; ain unchanged.
REQ-012 ARMED: trigger with posttrig_i != 0 -> POST, load remaining = posttrig_i; trigger with posttrig_i == 0 -> FROZEN.
REQ-013 POST: each accepted sample decrements remaining; accepted sample at remaining == 1 is written, then -> FROZEN.
REQ-014 Sample accepted iff sample_valid & (ARMED|POST) & !rd_request; accepted sample on trigger cycle counts as pre-trigger.
REQ-015 Accepted sample -> next cycle wr_en = 1, wr_addr = ain before increment, wr_data = din; ain += 1 mod 2^SIZE at the same edge.
REQ-016 wr_en SHALL be 0 in every cycle not following an accepted sample; no writes in IDLE or FROZEN.
REQ-017 trig_addr SHALL capture ain after any same-cycle increment on the trigger edge.
REQ-018 wrapped SHALL set when ain rolls over from 2^SIZE-1 to 0 while busy; sticky until arm in IDLE.
REQ-019 overrun SHALL set when sample_valid & busy & rd_request; sticky until arm in IDLE.
REQ-020 missed_trig SHALL increment, saturating at 255, on trigger in IDLE, POST or FROZEN; cleared only by rst.
REQ-021 FROZEN: falling edge of rd_request (rd_request_q=1, rd_request=0) with ro_done_n = 0 -> IDLE; with ro_done_n = 1 remains FROZEN (aborted readout, re-readable).
REQ-022 arm outside IDLE SHALL be ignored; trigger and arm on the same cycle in IDLE -> ARMED only.
REQ-023 SIZE-bit arithmetic throughout, wrap-around modulo 2^SIZE, no saturation on ain.

Reset
REQ-024 rst SHALL force state IDLE, ain = 0, trig_addr = 0, remaining = 0, wr_en = 0, wr_addr = 0, wr_data = 0, wrapped = 0, overrun = 0, missed_trig = 0, rd_request_q = 0.
REQ-025 rst mid-acquisition or mid-readout SHALL abort immediately; no write issued on the cycle after rst.

Structure
REQ-026 FSM state encoding and default SIZE/DWIDTH SHALL live in the shared mmaps package/include.
REQ-027 Post-trigger down-counter SHALL be sub-module ring_posttrig_cnt (load, decrement, last flag).

Verification
REQ-028 arm, 5 samples, trigger, posttrig_i=3, 5 more samples -> 8 writes at addr 0..7, trig_addr=5, FROZEN after write 7, samples 9-10 not written.
REQ-029 ain preset to 4094 via 4094 samples, arm continuous, 3 samples -> addrs 4094, 4095, 0; wrapped=1.
REQ-030 posttrig_i=0, trigger with sample_valid same cycle -> sample written, FROZEN next cycle, trig_addr = ain after that write.
REQ-031 FROZEN, rd_request 1 then 0 with ro_done_n=1 -> stays FROZEN; repeat with ro_done_n=0 -> IDLE.
REQ-032 ARMED, rd_request=1 with 2 samples -> no writes, overrun=1; 3 triggers in IDLE -> missed_trig=3.
REQ-033 rst asserted in POST -> next cycle state IDLE, ain=0, wr_en=0, all flags 0.
